mips_hazard_ctrl: RTL and testbench
===================================

Name: mips_hazard_ctrl

Overview:
- Parametrised hazard and pipeline-control unit for the 5-stage MIPS pipeline (IF, ID, EX, MEM, WB).
- Generates the following, which the current pipeline lacks:
  - EX-stage operand forwarding selects.
  - Load-use stall.
  - Branch flush (branch resolved in MEM).
  - Instruction-fetch miss freeze driven by the fetch hit bit.
- Also keeps saturating performance counters and a miss-timeout watchdog.
- Sits beside the stage registers and drives their write-enable and flush inputs, plus the PC write enable.

Parameters:
REG_ADDR_W, 5, register-specifier width
CNT_W, 16, width of each performance counter
MISS_TIMEOUT, 64, consecutive MISS-state cycles that set miss_timeout (>=1)
FLUSH_EX_MEM, 1, 1 = branch_taken also flushes EX/MEM; 0 = only IF/ID and ID/EX are flushed

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
hit  in  1  fetch hit for the current IF instruction
id_rs  in  REG_ADDR_W  rs of the instruction in ID
id_rt  in  REG_ADDR_W  rt of the instruction in ID
id_uses_rt  in  1  ID instruction reads rt (R-type, store, branch)
ex_rs  in  REG_ADDR_W  rs of the instruction in EX
ex_rt  in  REG_ADDR_W  rt of the instruction in EX
ex_mem_read  in  1  instruction in EX is a load
ex_write_reg  in  REG_ADDR_W  destination of the instruction in EX
mem_reg_write  in  1  EX/MEM RegWrite
mem_write_reg  in  REG_ADDR_W  EX/MEM destination
wb_reg_write  in  1  MEM/WB RegWrite
wb_write_reg  in  REG_ADDR_W  MEM/WB destination
branch_taken  in  1  PCSrc (Branch & zero) from EX/MEM
pc_write  out  1  PC load enable
if_id_write  out  1  IF/ID load enable
if_id_flush  out  1  load bubble into IF/ID
id_ex_flush  out  1  load bubble into ID/EX
ex_mem_flush  out  1  load bubble into EX/MEM
fwd_a  out  2  ALU A source: 00 regfile, 10 EX/MEM ALUResult, 01 WB writeData
fwd_b  out  2  ALU B source, same encoding
miss_cancel  out  1  pulse: outstanding fetch miss abandoned by redirect
miss_timeout  out  1  sticky watchdog flag
stall_cnt  out  CNT_W  load-use stall cycles
flush_cnt  out  CNT_W  branch flush events
miss_cnt  out  CNT_W  fetch-miss episodes

Behaviour:

Reset (async):
- Effects: state=RUN, all counters 0, miss timer 0, miss_timeout=0.
- Outputs while rst high: pc_write=0, if_id_write=0, all flushes=1, fwd_a=fwd_b=00, miss_cancel=0.

Forwarding (combinational, operand A shown; B identical using ex_rt):
- 10 if mem_reg_write && mem_write_reg!=0 && mem_write_reg==ex_rs.
- Else 01 if wb_reg_write && wb_write_reg!=0 && wb_write_reg==ex_rs.
- Else 00.
- EX/MEM wins over WB. Register 0 is never forwarded.

Load-use condition:
- lu = ex_mem_read && ex_write_reg!=0 && (ex_write_reg==id_rs || (id_uses_rt && ex_write_reg==id_rt)).

Control priority each cycle, highest first:
1. branch_taken:
   - pc_write=1, if_id_flush=1, id_ex_flush=1, ex_mem_flush=FLUSH_EX_MEM.
   - lu and hit are ignored.
   - flush_cnt+1.
2. lu:
   - pc_write=0, if_id_write=0, id_ex_flush=1.
   - stall_cnt+1.
   - Exactly one stall cycle per load, since the load advances to MEM next cycle.
3. hit=0:
   - pc_write=0, if_id_flush=1.
   - Back end keeps running.
4. Otherwise: pc_write=1, if_id_write=1, all flushes 0.

Combined lu with hit=0:
- The lu hold applies: if_id_write=0, if_id_flush=0, id_ex_flush=1, pc_write=0.
- The ID instruction is kept and no bubble is written to IF/ID.

FSM (registered state):
- RUN -> MISS: hit=0 && !branch_taken; miss_cnt+1 on entry.
- MISS -> RUN: hit=1.
- MISS -> RUN on branch_taken, with miss_cancel=1 for that cycle only.
  - If hit=1 and branch_taken together in MISS: go to RUN, miss_cancel=0.
- Control outputs in MISS follow the priority rules above; state only affects counters, miss_cancel and the timer.

Miss timer:
- Increments each clock in MISS; cleared on any exit from MISS.
- When it reaches MISS_TIMEOUT, miss_timeout is set and stays 1 until rst.
- Timer saturates at MISS_TIMEOUT.

Counters:
- All saturate at all-ones and never wrap.
- Multiple counters may increment in the same cycle.
- Counters hold while rst is low and no event occurs.

Test Plan:
- rst high mid-run with counters nonzero -> counters read 0, pc_write=0, all flushes=1 immediately (asynchronous); RUN state after release.
- Forwarding: EX/MEM writes r3 and MEM/WB writes r3, ex_rs=3 -> fwd_a=10. Same with writes to r0 -> fwd_a=00. Only WB writes r4, ex_rt=4 -> fwd_b=01.
- lw r2 in EX, add using rt=r2 in ID with id_uses_rt=1 -> exactly one cycle of pc_write=0, if_id_write=0, id_ex_flush=1; stall_cnt=1. With id_uses_rt=0 -> no stall.
- branch_taken=1 in the same cycle as lu and hit=0 -> pc_write=1, if_id_flush=id_ex_flush=1, ex_mem_flush=1 (FLUSH_EX_MEM=1), stall_cnt unchanged, flush_cnt+1, state stays RUN.
- hit=0 for 3 cycles, then branch_taken -> miss_cnt=1, if_id_flush=1 for 3 cycles, miss_cancel pulses for one cycle, state RUN.
- MISS_TIMEOUT=4, hit held low 4 cycles -> miss_timeout=1 after the 4th MISS clock; stays 1 after hit returns until rst. stall_cnt preloaded to all-ones plus one more stall -> still all-ones.

Source files
------------

// File: rtl/mips_hazard_ctrl_if.sv
// Pipeline <-> hazard-unit signal bundle for the 5-stage MIPS pipeline.
// The master is the pipeline datapath; the slave is mips_hazard_ctrl.
interface mips_hazard_ctrl_if #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
);
    // Datapath -> hazard unit
    logic                  hit;
    logic [REG_ADDR_W-1:0] id_rs;
    logic [REG_ADDR_W-1:0] id_rt;
    logic                  id_uses_rt;
    logic [REG_ADDR_W-1:0] ex_rs;
    logic [REG_ADDR_W-1:0] ex_rt;
    logic                  ex_mem_read;
    logic [REG_ADDR_W-1:0] ex_write_reg;
    logic                  mem_reg_write;
    logic [REG_ADDR_W-1:0] mem_write_reg;
    logic                  wb_reg_write;
    logic [REG_ADDR_W-1:0] wb_write_reg;
    logic                  branch_taken;

    // Hazard unit -> datapath
    logic                  pc_write;
    logic                  if_id_write;
    logic                  if_id_flush;
    logic                  id_ex_flush;
    logic                  ex_mem_flush;
    logic [1:0]            fwd_a;
    logic [1:0]            fwd_b;
    logic                  miss_cancel;
    logic                  miss_timeout;
    logic [CNT_W-1:0]      stall_cnt;
    logic [CNT_W-1:0]      flush_cnt;
    logic [CNT_W-1:0]      miss_cnt;

    modport master (
        output hit, id_rs, id_rt, id_uses_rt, ex_rs, ex_rt, ex_mem_read,
               ex_write_reg, mem_reg_write, mem_write_reg, wb_reg_write,
               wb_write_reg, branch_taken,
        input  pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_flush,
               fwd_a, fwd_b, miss_cancel, miss_timeout, stall_cnt, flush_cnt,
               miss_cnt
    );

    modport slave (
        input  hit, id_rs, id_rt, id_uses_rt, ex_rs, ex_rt, ex_mem_read,
               ex_write_reg, mem_reg_write, mem_write_reg, wb_reg_write,
               wb_write_reg, branch_taken,
        output pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_flush,
               fwd_a, fwd_b, miss_cancel, miss_timeout, stall_cnt, flush_cnt,
               miss_cnt
    );
endinterface

// File: rtl/mips_hazard_ctrl.sv
// Hazard and pipeline-control unit for the 5-stage MIPS pipeline:
// EX operand forwarding, load-use stall, branch flush (resolved in MEM),
// fetch-miss freeze, saturating performance counters and a miss watchdog.
module mips_hazard_ctrl #(
    parameter int REG_ADDR_W   = 5,
    parameter int CNT_W        = 16,
    parameter int MISS_TIMEOUT = 64,
    parameter int FLUSH_EX_MEM = 1
) (
    input  logic             clk,
    input  logic             rst,
    mips_hazard_ctrl_if.slave hz
);

    localparam int                TMR_W    = $clog2(MISS_TIMEOUT + 1);
    localparam logic [TMR_W-1:0]  TMR_MAX  = TMR_W'(MISS_TIMEOUT);
    localparam logic [TMR_W-1:0]  TMR_ONE  = TMR_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    typedef enum logic {RUN, MISS} state_t;

    state_t           state_q, state_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic             mto_q, mto_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] flush_q, flush_d;
    logic [CNT_W-1:0] miss_q, miss_d;
    logic             lu;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_ONE;
    endfunction

    // EX/MEM result takes precedence over WB; r0 is hard-wired and never forwarded.
    function automatic logic [1:0] fwd_sel(
        input logic [REG_ADDR_W-1:0] src,
        input logic                  mem_we,
        input logic [REG_ADDR_W-1:0] mem_rd,
        input logic                  wb_we,
        input logic [REG_ADDR_W-1:0] wb_rd
    );
        if (mem_we && (mem_rd != '0) && (mem_rd == src))
            return 2'b10;
        else if (wb_we && (wb_rd != '0) && (wb_rd == src))
            return 2'b01;
        return 2'b00;
    endfunction

    // Load-use: the load in EX produces a register the ID instruction reads.
    always_comb begin
        lu = hz.ex_mem_read && (hz.ex_write_reg != '0) &&
             ((hz.ex_write_reg == hz.id_rs) ||
              (hz.id_uses_rt && (hz.ex_write_reg == hz.id_rt)));
    end

    // Forwarding selects, forced to the register-file path while in reset.
    always_comb begin
        hz.fwd_a = 2'b00;
        hz.fwd_b = 2'b00;
        if (!rst) begin
            hz.fwd_a = fwd_sel(hz.ex_rs, hz.mem_reg_write, hz.mem_write_reg,
                               hz.wb_reg_write, hz.wb_write_reg);
            hz.fwd_b = fwd_sel(hz.ex_rt, hz.mem_reg_write, hz.mem_write_reg,
                               hz.wb_reg_write, hz.wb_write_reg);
        end
    end

    // Stage enables/flushes by priority: reset, branch, load-use, fetch miss, run.
    // A load-use hold during a fetch miss keeps IF/ID intact rather than bubbling it.
    always_comb begin
        hz.pc_write     = 1'b1;
        hz.if_id_write  = 1'b1;
        hz.if_id_flush  = 1'b0;
        hz.id_ex_flush  = 1'b0;
        hz.ex_mem_flush = 1'b0;
        if (rst) begin
            hz.pc_write     = 1'b0;
            hz.if_id_write  = 1'b0;
            hz.if_id_flush  = 1'b1;
            hz.id_ex_flush  = 1'b1;
            hz.ex_mem_flush = 1'b1;
        end else if (hz.branch_taken) begin
            hz.if_id_flush  = 1'b1;
            hz.id_ex_flush  = 1'b1;
            hz.ex_mem_flush = (FLUSH_EX_MEM != 0);
        end else if (lu) begin
            hz.pc_write     = 1'b0;
            hz.if_id_write  = 1'b0;
            hz.id_ex_flush  = 1'b1;
        end else if (!hz.hit) begin
            hz.pc_write     = 1'b0;
            hz.if_id_flush  = 1'b1;
        end
    end

    // A redirect while a miss is outstanding abandons it; a hit in the same cycle does not.
    always_comb begin
        hz.miss_cancel = !rst && (state_q == MISS) && hz.branch_taken && !hz.hit;
    end

    // Next state for the miss FSM, watchdog timer and performance counters.
    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        mto_d   = mto_q;
        stall_d = stall_q;
        flush_d = flush_q;
        miss_d  = miss_q;

        if (hz.branch_taken)
            flush_d = sat_inc(flush_q);
        else if (lu)
            stall_d = sat_inc(stall_q);

        unique case (state_q)
            RUN: begin
                if (!hz.hit && !hz.branch_taken) begin
                    state_d = MISS;
                    tmr_d   = '0;
                    miss_d  = sat_inc(miss_q);
                end
            end
            MISS: begin
                if (hz.hit || hz.branch_taken) begin
                    state_d = RUN;
                    tmr_d   = '0;
                end else if (tmr_q != TMR_MAX) begin
                    tmr_d = tmr_q + TMR_ONE;
                end
            end
            default: state_d = RUN;
        endcase

        if (tmr_d == TMR_MAX)
            mto_d = 1'b1;
    end

    // State, timer, sticky watchdog flag and counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            tmr_q   <= '0;
            mto_q   <= 1'b0;
            stall_q <= '0;
            flush_q <= '0;
            miss_q  <= '0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            mto_q   <= mto_d;
            stall_q <= stall_d;
            flush_q <= flush_d;
            miss_q  <= miss_d;
        end
    end

    assign hz.miss_timeout = mto_q;
    assign hz.stall_cnt    = stall_q;
    assign hz.flush_cnt    = flush_q;
    assign hz.miss_cnt     = miss_q;

endmodule

// File: tb/tb_mips_hazard_ctrl.sv
// Scoreboard bench for mips_hazard_ctrl: each stimulus cycle pushes the
// hand-computed expected outputs; a monitor pops and compares on the falling edge.
module tb_mips_hazard_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    mips_hazard_ctrl_if #(.REG_ADDR_W(5), .CNT_W(4)) hz ();

    mips_hazard_ctrl #(
        .REG_ADDR_W  (5),
        .CNT_W       (4),
        .MISS_TIMEOUT(4),
        .FLUSH_EX_MEM(1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .hz (hz)
    );

    // ctl = {pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_flush}
    typedef struct packed {
        logic [4:0] ctl;
        logic [1:0] fa;
        logic [1:0] fb;
        logic       mc;
        logic       mt;
        logic [3:0] sc;
        logic [3:0] fc;
        logic [3:0] mcn;
    } obs_t;

    typedef struct {
        string nm;
        obs_t  exp;
    } item_t;

    item_t q[$];
    int    n_cmp = 0;
    int    n_bad = 0;

    function automatic string fmt(input obs_t o);
        return $sformatf("ctl=%b fa=%b fb=%b mc=%b mt=%b stall=%0d flush=%0d miss=%0d",
                         o.ctl, o.fa, o.fb, o.mc, o.mt, o.sc, o.fc, o.mcn);
    endfunction

    // Monitor: outputs are sampled mid-cycle, well away from the rising edge.
    initial begin
        item_t it;
        obs_t  got;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                it  = q.pop_front();
                got = '{ctl: {hz.pc_write, hz.if_id_write, hz.if_id_flush,
                              hz.id_ex_flush, hz.ex_mem_flush},
                        fa: hz.fwd_a, fb: hz.fwd_b, mc: hz.miss_cancel,
                        mt: hz.miss_timeout, sc: hz.stall_cnt,
                        fc: hz.flush_cnt, mcn: hz.miss_cnt};
                n_cmp++;
                if (got !== it.exp) begin
                    n_bad++;
                    $display("FAIL %s: got %s, required %s", it.nm, fmt(got), fmt(it.exp));
                end
            end
        end
    end

    task automatic idle();
        hz.hit           = 1'b1;
        hz.id_rs         = '0;
        hz.id_rt         = '0;
        hz.id_uses_rt    = 1'b0;
        hz.ex_rs         = '0;
        hz.ex_rt         = '0;
        hz.ex_mem_read   = 1'b0;
        hz.ex_write_reg  = '0;
        hz.mem_reg_write = 1'b0;
        hz.mem_write_reg = '0;
        hz.wb_reg_write  = 1'b0;
        hz.wb_write_reg  = '0;
        hz.branch_taken  = 1'b0;
    endtask

    task automatic load_use(input logic [4:0] rd);
        hz.ex_mem_read  = 1'b1;
        hz.ex_write_reg = rd;
        hz.id_rs        = rd;
    endtask

    // Push the expectation for the inputs just driven, then advance one cycle.
    task automatic go(input string nm, input logic [4:0] ctl, input logic [1:0] fa,
                      input logic [1:0] fb, input logic mc, input logic mt,
                      input int s, input int f, input int m);
        item_t it;
        it.nm  = nm;
        it.exp = '{ctl: ctl, fa: fa, fb: fb, mc: mc, mt: mt,
                   sc: 4'(s), fc: 4'(f), mcn: 4'(m)};
        q.push_back(it);
        @(posedge clk);
        #1;
    endtask

    localparam logic [4:0] C_RUN = 5'b11000;
    localparam logic [4:0] C_BR  = 5'b11111;
    localparam logic [4:0] C_LU  = 5'b00010;
    localparam logic [4:0] C_MS  = 5'b01100;
    localparam logic [4:0] C_RST = 5'b00111;

    initial begin
        idle();
        rst = 1'b1;
        @(posedge clk);
        #1;
        go("reset", C_RST, 2'b00, 2'b00, 0, 0, 0, 0, 0);
        rst = 1'b0;

        idle(); go("idle", C_RUN, 2'b00, 2'b00, 0, 0, 0, 0, 0);
        idle(); hz.mem_reg_write = 1; hz.mem_write_reg = 3; hz.wb_reg_write = 1;
        hz.wb_write_reg = 3; hz.ex_rs = 3;
        go("fwd_mem_over_wb", C_RUN, 2'b10, 2'b00, 0, 0, 0, 0, 0);
        idle(); hz.mem_reg_write = 1; hz.wb_reg_write = 1;
        go("fwd_r0", C_RUN, 2'b00, 2'b00, 0, 0, 0, 0, 0);
        idle(); hz.wb_reg_write = 1; hz.wb_write_reg = 4; hz.ex_rt = 4; hz.ex_rs = 1;
        go("fwd_wb_b", C_RUN, 2'b00, 2'b01, 0, 0, 0, 0, 0);
        idle(); hz.mem_reg_write = 1; hz.mem_write_reg = 7; hz.ex_rs = 7; hz.ex_rt = 7;
        go("fwd_mem_ab", C_RUN, 2'b10, 2'b10, 0, 0, 0, 0, 0);

        idle(); hz.ex_mem_read = 1; hz.ex_write_reg = 2; hz.id_rt = 2;
        hz.id_uses_rt = 1; hz.id_rs = 5;
        go("lu_rt", C_LU, 2'b00, 2'b00, 0, 0, 0, 0, 0);
        idle(); go("after_lu", C_RUN, 2'b00, 2'b00, 0, 0, 1, 0, 0);
        idle(); hz.ex_mem_read = 1; hz.ex_write_reg = 2; hz.id_rt = 2; hz.id_rs = 5;
        go("lu_rt_unused", C_RUN, 2'b00, 2'b00, 0, 0, 1, 0, 0);
        idle(); load_use(6);
        go("lu_rs", C_LU, 2'b00, 2'b00, 0, 0, 1, 0, 0);
        idle(); load_use(0);
        go("lu_r0", C_RUN, 2'b00, 2'b00, 0, 0, 2, 0, 0);

        idle(); load_use(2); hz.branch_taken = 1; hz.hit = 0;
        go("br_over_lu_miss", C_BR, 2'b00, 2'b00, 0, 0, 2, 0, 0);
        idle(); hz.branch_taken = 1; hz.hit = 0;
        go("br_stays_run", C_BR, 2'b00, 2'b00, 0, 0, 2, 1, 0);
        idle(); go("after_br", C_RUN, 2'b00, 2'b00, 0, 0, 2, 2, 0);

        idle(); hz.hit = 0; go("miss1", C_MS, 2'b00, 2'b00, 0, 0, 2, 2, 0);
        idle(); hz.hit = 0; go("miss2", C_MS, 2'b00, 2'b00, 0, 0, 2, 2, 1);
        idle(); hz.hit = 0; go("miss3", C_MS, 2'b00, 2'b00, 0, 0, 2, 2, 1);
        idle(); hz.hit = 0; hz.branch_taken = 1;
        go("miss_cancel", C_BR, 2'b00, 2'b00, 1, 0, 2, 2, 1);
        idle(); go("after_cancel", C_RUN, 2'b00, 2'b00, 0, 0, 2, 3, 1);

        idle(); hz.hit = 0; go("miss_b", C_MS, 2'b00, 2'b00, 0, 0, 2, 3, 1);
        idle(); hz.branch_taken = 1;
        go("miss_hit_br", C_BR, 2'b00, 2'b00, 0, 0, 2, 3, 2);
        idle(); go("after_hit_br", C_RUN, 2'b00, 2'b00, 0, 0, 2, 4, 2);

        idle(); hz.hit = 0; go("miss_c", C_MS, 2'b00, 2'b00, 0, 0, 2, 4, 2);
        idle(); hz.hit = 0; load_use(2);
        go("lu_in_miss", C_LU, 2'b00, 2'b00, 0, 0, 2, 4, 3);
        idle(); go("miss_c_hit", C_RUN, 2'b00, 2'b00, 0, 0, 3, 4, 3);

        idle(); hz.hit = 0; go("to_enter", C_MS, 2'b00, 2'b00, 0, 0, 3, 4, 3);
        for (int i = 1; i <= 4; i++) begin
            idle(); hz.hit = 0;
            go($sformatf("to_wait%0d", i), C_MS, 2'b00, 2'b00, 0, 0, 3, 4, 4);
        end
        idle(); hz.hit = 0; go("to_set", C_MS, 2'b00, 2'b00, 0, 1, 3, 4, 4);
        idle(); go("to_hit", C_RUN, 2'b00, 2'b00, 0, 1, 3, 4, 4);
        idle(); go("to_sticky", C_RUN, 2'b00, 2'b00, 0, 1, 3, 4, 4);

        for (int i = 0; i < 13; i++) begin
            idle(); load_use(9);
            go($sformatf("stall_sat%0d", i), C_LU, 2'b00, 2'b00, 0, 1,
               (3 + i > 15) ? 15 : 3 + i, 4, 4);
        end
        idle(); go("stall_sat_hold", C_RUN, 2'b00, 2'b00, 0, 1, 15, 4, 4);

        idle(); hz.mem_reg_write = 1; hz.mem_write_reg = 3; hz.ex_rs = 3;
        rst = 1'b1;
        go("async_reset", C_RST, 2'b00, 2'b00, 0, 0, 0, 0, 0);
        rst = 1'b0;
        idle(); go("post_reset", C_RUN, 2'b00, 2'b00, 0, 0, 0, 0, 0);
        idle(); hz.hit = 0; go("post_miss", C_MS, 2'b00, 2'b00, 0, 0, 0, 0, 0);
        idle(); hz.hit = 0; hz.branch_taken = 1;
        go("post_cancel", C_BR, 2'b00, 2'b00, 1, 0, 0, 0, 1);
        idle(); go("post_idle", C_RUN, 2'b00, 2'b00, 0, 0, 0, 1, 1);

        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        #1;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending, required 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
